rc5_arbiter: RTL
================

RC5_ARBITER -- requirements
Module: rc5_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20, is the number of WAIT cycles allowed for eng_done before the block aborts the transaction.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 req0_vld  input  1  requester 0 has a 64-bit block to encrypt.
REQ-005 req0_din  input  64  requester 0 block; {A[31:0],B[31:0]}.
REQ-006 req0_rdy  output  1  requester 0 transfer accepted when req0_vld & req0_rdy.
REQ-007 req1_vld / req1_din / req1_rdy  input/input/output  1/64/1  requester 1; same meaning as requester 0.
REQ-008 eng_start  output  1  one-cycle pulse launching the shared RC5 engine.
REQ-009 eng_din  output  64  block presented to the engine; valid while eng_start=1.
REQ-010 eng_done  input  1  one-cycle pulse from the engine; result valid on eng_dout.
REQ-011 eng_dout  input  64  engine result.
REQ-012 rsp_vld  output  1  response valid.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_dout  output  64  encrypted block, or 0 on timeout.
REQ-015 rsp_err  output  1  1 = transaction aborted by timeout.
REQ-016 rsp_rdy  input  1  consumer accepts the response when rsp_vld & rsp_rdy.

Function
REQ-017 The FSM states SHALL be IDLE, ISSUE, WAIT and RESP; exactly one transaction is in flight at a time.
REQ-018 In IDLE, grant: only req0_vld -> 0; only req1_vld -> 1; both -> the requester not equal to last_grant (round-robin).
REQ-019 reqN_rdy SHALL be 1 only in IDLE and only for the granted requester; it is 0 in every other state.
REQ-020 On acceptance: capture din and id, set last_grant = id, go to ISSUE.
REQ-021 ISSUE lasts exactly one cycle, with eng_start=1 and eng_din = captured block; then go to WAIT with the timer = 0.
REQ-022 WAIT, eng_done=1: capture eng_dout into rsp_dout, set rsp_err=0, go to RESP.
REQ-023 WAIT, no done: timer increments; when timer == TIMEOUT_CYC-1 set rsp_dout=0, rsp_err=1 and go to RESP.
REQ-024 eng_done in the same cycle as timeout expiry: done wins, rsp_err=0.
REQ-025 eng_done outside WAIT SHALL be ignored with no state change; eng_dout is sampled only in WAIT.
REQ-026 RESP: rsp_vld=1; rsp_id, rsp_dout and rsp_err are held stable until rsp_rdy=1; on handshake, rsp_vld drops next cycle and the FSM returns to IDLE.
REQ-027 Latency: accept at cycle T, eng_start at T+1, done at T+1+k, rsp_vld first high at T+2+k.
REQ-028 A new request SHALL NOT be accepted in the handshake cycle of RESP (one IDLE cycle minimum between transactions).
REQ-029 A requester deasserting vld before handshake SHALL lose no data and cause no grant change.
REQ-030 The timer SHALL be 5 bits, saturating, and never wrap.
REQ-031 eng_start SHALL never be asserted twice for one transaction.

Reset
REQ-032 clr=0 forces immediately: state=IDLE, last_grant=1 (req0 wins first tie), timer=0, eng_start=0, eng_din=0, rsp_vld=0, rsp_id=0, rsp_dout=0, rsp_err=0.
REQ-033 clr=0 mid-transaction SHALL abandon it with no response; a late eng_done after release SHALL be ignored per REQ-025.
REQ-034 The first acceptance is possible on the first rising edge after clr rises.

Verification
REQ-035 Single request: req0 din=64'h0123456789ABCDEF, engine done after 13 cycles with eng_dout=64'hA5A5A5A55A5A5A5A -> eng_start one pulse at T+1, rsp_vld at T+15, rsp_id=0, rsp_err=0, rsp_dout=64'hA5A5A5A55A5A5A5A.
REQ-036 Both requesters valid continuously for 4 transactions after reset -> grant order 0,1,0,1; rsp_id follows the same order.
REQ-037 Engine never responds -> rsp_vld rises TIMEOUT_CYC+1 cycles after eng_start, rsp_err=1, rsp_dout=0; an eng_done injected in that exact expiry cycle instead gives rsp_err=0.
REQ-038 rsp_rdy held low 10 cycles in RESP -> outputs stable, req0_rdy=req1_rdy=0, no eng_start; rsp_rdy=1 -> return to IDLE.
REQ-039 clr pulsed low during WAIT, then eng_done arrives -> all outputs 0, no rsp_vld, next request proceeds normally with req0 winning a tie.

Source files
------------

// File: rtl/rc5_arbiter_if.sv
// Handshake bundle between two requesters, the shared RC5 engine and the
// response consumer. The slave modport is the arbiter's view of the bundle.
interface rc5_arbiter_if;
    logic        req0_vld;
    logic [63:0] req0_din;
    logic        req0_rdy;
    logic        req1_vld;
    logic [63:0] req1_din;
    logic        req1_rdy;
    logic        eng_start;
    logic [63:0] eng_din;
    logic        eng_done;
    logic [63:0] eng_dout;
    logic        rsp_vld;
    logic        rsp_id;
    logic [63:0] rsp_dout;
    logic        rsp_err;
    logic        rsp_rdy;

    modport slave (
        input  req0_vld, req0_din, req1_vld, req1_din,
        input  eng_done, eng_dout, rsp_rdy,
        output req0_rdy, req1_rdy, eng_start, eng_din,
        output rsp_vld, rsp_id, rsp_dout, rsp_err
    );

    modport master (
        output req0_vld, req0_din, req1_vld, req1_din,
        output eng_done, eng_dout, rsp_rdy,
        input  req0_rdy, req1_rdy, eng_start, eng_din,
        input  rsp_vld, rsp_id, rsp_dout, rsp_err
    );
endinterface

// File: rtl/rc5_arbiter.sv
// Two-requester round-robin front end for a single shared RC5 engine; one
// transaction in flight, with an abort after TIMEOUT_CYC cycles of engine silence.
module rc5_arbiter #(
    parameter int TIMEOUT_CYC = 20
) (
    input logic          clk,
    input logic          clr,
    rc5_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYC - 1);
    localparam logic [4:0] TMR_MAX  = 5'h1F;

    state_t      state_q;
    logic        last_grant_q;
    logic        id_q;
    logic [4:0]  timer_q;
    logic        eng_start_q;
    logic [63:0] eng_din_q;
    logic        rsp_vld_q;
    logic        rsp_id_q;
    logic [63:0] rsp_dout_q;
    logic        rsp_err_q;

    logic        grant_vld_s;
    logic        grant_id_s;
    logic [63:0] sel_din_s;

    // Grant decision in IDLE; a tie goes to whoever was not served last.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.req0_vld && bus.req1_vld) begin
                grant_vld_s = 1'b1;
                grant_id_s  = ~last_grant_q;
            end else if (bus.req0_vld) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b0;
            end else if (bus.req1_vld) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    assign sel_din_s    = grant_id_s ? bus.req1_din : bus.req0_din;
    assign bus.req0_rdy = grant_vld_s & ~grant_id_s;
    assign bus.req1_rdy = grant_vld_s &  grant_id_s;

    // Transaction FSM; all engine and response outputs are registered here.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            timer_q      <= 5'd0;
            eng_start_q  <= 1'b0;
            eng_din_q    <= 64'h0;
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_dout_q   <= 64'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_s) begin
                        eng_din_q    <= sel_din_s;
                        id_q         <= grant_id_s;
                        last_grant_q <= grant_id_s;
                        eng_start_q  <= 1'b1;
                        state_q      <= S_ISSUE;
                    end else begin
                        state_q      <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    eng_start_q <= 1'b0;
                    timer_q     <= 5'd0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (bus.eng_done) begin
                        rsp_dout_q <= bus.eng_dout;
                        rsp_err_q  <= 1'b0;
                        rsp_id_q   <= id_q;
                        rsp_vld_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (timer_q == TMO_LAST) begin
                        rsp_dout_q <= 64'h0;
                        rsp_err_q  <= 1'b1;
                        rsp_id_q   <= id_q;
                        rsp_vld_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (timer_q != TMR_MAX) begin
                        timer_q    <= timer_q + 5'd1;
                    end else begin
                        timer_q    <= timer_q;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        state_q   <= S_RESP;
                    end
                end
                default: begin
                    eng_start_q <= 1'b0;
                    rsp_vld_q   <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.eng_start = eng_start_q;
    assign bus.eng_din   = eng_din_q;
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
